psum_binarizer: RTL

Downstream stage of the PE row chain. Consumes the serial `psum_out` stream of the last PE in a row and accumulates `PASSES` consecutive partial sums into one output-neuron pre-activation. It binarizes each result against a signed threshold (sign activation, 1 = +1). Resulting bits are packed into 27-bit activation words, the slice width the next layer's PEs take on `activation_in`, with a valid/ready handshake and backpressure toward the PE row.

---
 rtl/psum_binarizer_pkg.sv | 34 +++
 rtl/psum_binarizer_bit_packer.sv | 92 +++++++++
 rtl/psum_binarizer.sv | 73 +++++++
 3 files changed

// File: rtl/psum_binarizer_pkg.sv
// Shared definitions for the psum binarizer slice: default widths, the PE
// activation slice width, packer state encoding and the saturating add helper.
package psum_binarizer_pkg;

    localparam int PSUM_W = 14;
    localparam int ACC_W  = 18;
    localparam int PACK_W = 27;

    // Encoding is {pending, output_full}.
    typedef enum logic [1:0] {
        EMPTY        = 2'b00,
        FULL         = 2'b01,
        FULL_PENDING = 2'b11
    } pack_state_t;

    // Signed add clipped to the limits of a w-bit two's-complement value.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                    input logic signed [63:0] b,
                                                    input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] s;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        s  = a + b;
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/psum_binarizer_bit_packer.sv
// Packs binarized neuron bits MSB-first into PACK-bit words and holds up to one
// extra complete word while the output register waits on the consumer.
module bit_packer
    import psum_binarizer_pkg::*;
#(
    parameter int PACK = PACK_W
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            bit_in,
    input  logic            bit_valid,
    output logic            bit_ready,
    output logic [PACK-1:0] act_out,
    output logic            act_valid_out,
    input  logic            act_ready_in
);

    // state        | meaning
    // EMPTY        | output register holds no word
    // FULL         | output register valid, pack register filling
    // FULL_PENDING | output valid and a finished word waits in the pack register

    localparam int BCW = $clog2(PACK);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(PACK - 1);

    pack_state_t     state;
    pack_state_t     state_next;
    logic [PACK-1:0] shift_reg;
    logic [PACK-1:0] new_word;
    logic [BCW-1:0]  bit_cnt;
    logic            word_done;
    logic            drain;
    logic            pending;

    assign new_word  = {shift_reg[PACK-2:0], bit_in};
    assign word_done = bit_valid && (bit_cnt == LAST_BIT);
    assign drain     = act_valid_out && act_ready_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (word_done) state_next = FULL;
            end
            FULL: begin
                if (word_done && !drain) begin
                    state_next = FULL_PENDING;
                end else if (!word_done && drain) begin
                    state_next = EMPTY;
                end
            end
            FULL_PENDING: begin
                if (drain) state_next = FULL;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        act_valid_out = (state != EMPTY);
        pending       = (state == FULL_PENDING);
        bit_ready     = !pending;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            act_out   <= '0;
        end else begin
            if (bit_valid) begin
                shift_reg <= new_word;
                bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
            end
            // A finished word bypasses the pack register when the output frees up this edge.
            if (word_done && (state == EMPTY || drain)) begin
                act_out <= new_word;
            end else if (pending && drain) begin
                act_out <= shift_reg;
            end
        end
    end

endmodule

// File: rtl/psum_binarizer.sv
// Accumulates PASSES partial sums per neuron, sign-binarizes against a threshold
// and streams packed activation words. Define PSUM_SATURATE_EN for a saturating accumulator.
module psum_binarizer
    import psum_binarizer_pkg::*;
#(
    parameter int WIDTH     = PSUM_W,
    parameter int ACC_WIDTH = ACC_W,
    parameter int PASSES    = 4,
    parameter int PACK      = PACK_W
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic signed [WIDTH-1:0]     psum_in,
    input  logic                        psum_valid_in,
    output logic                        psum_ready_out,
    input  logic signed [ACC_WIDTH-1:0] threshold_in,
    output logic [PACK-1:0]             act_out,
    output logic                        act_valid_out,
    input  logic                        act_ready_in
);

    localparam int PCW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [PCW-1:0] LAST_PASS = PCW'(PASSES - 1);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] psum_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [PCW-1:0]              pass_cnt;
    logic                        psum_fire;
    logic                        bit_valid;
    logic                        act_bit;

    assign psum_fire = psum_valid_in && psum_ready_out;
    assign psum_ext  = ACC_WIDTH'(psum_in);
    // Pass 0 starts a fresh neuron, so the stale accumulator is ignored.
    assign acc_base  = (pass_cnt == '0) ? '0 : acc;

`ifdef PSUM_SATURATE_EN
    logic signed [63:0] sum_wide;
    assign sum_wide = sat_add(64'(acc_base), 64'(psum_ext), ACC_WIDTH);
    assign sum      = ACC_WIDTH'(sum_wide);
`else
    assign sum = acc_base + psum_ext;
`endif

    assign bit_valid = psum_fire && (pass_cnt == LAST_PASS);
    assign act_bit   = (sum >= threshold_in);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc      <= '0;
            pass_cnt <= '0;
        end else if (psum_fire) begin
            acc      <= sum;
            pass_cnt <= (pass_cnt == LAST_PASS) ? '0 : pass_cnt + 1'b1;
        end
    end

    bit_packer #(
        .PACK(PACK)
    ) u_packer (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bit_in       (act_bit),
        .bit_valid    (bit_valid),
        .bit_ready    (psum_ready_out),
        .act_out      (act_out),
        .act_valid_out(act_valid_out),
        .act_ready_in (act_ready_in)
    );

endmodule
